// File: rtl/ysyx_210247_redirect_ctrl.sv
// ysyx_210247_redirect_ctrl: arbitrates trap/mret/branch redirects, flushes the pipeline, then hands the target PC to IF
//   in : clk, rst, exc_op (0 none/1 ecall/2 mret/3 irq), exc_cause, csr_mepc, csr_mtvec, br_valid, br_target, if_ready
//   out: flush, new_pc_valid, new_pc, trap_taken, mret_taken, busy
module ysyx_210247_redirect_ctrl #(
  parameter int XLEN        = 64,
  parameter int TRAP_FLUSH  = 4,
  parameter int BR_FLUSH    = 1,
  parameter int CAUSE_W     = 6,
  parameter int VECTORED_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     exc_op,
  input  logic [XLEN-1:0] exc_cause,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_target,
  input  logic            if_ready,
  output logic            flush,
  output logic            new_pc_valid,
  output logic [XLEN-1:0] new_pc,
  output logic            trap_taken,
  output logic            mret_taken,
  output logic            busy
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  state_t state, state_nx;
  logic [31:0] cnt;
  logic [XLEN-1:0] tgt_q, tgt, base, off;
  logic first, trap_k, mret_k, is_exc, is_trap, is_mret, accept, vec;
  logic unused_cause;
  assign unused_cause = ^exc_cause[XLEN-1:CAUSE_W];
  assign is_trap = exc_op == 32'd1 || exc_op == 32'd3;
  assign is_mret = exc_op == 32'd2;
  assign is_exc  = is_trap || is_mret;
  assign accept  = state == IDLE && (is_exc || br_valid);
  assign base    = {csr_mtvec[XLEN-1:2], 2'b00};
  assign off     = {{(XLEN-CAUSE_W-2){1'b0}}, exc_cause[CAUSE_W-1:0], 2'b00};
  // MODE 2/3 fall back to direct; only MODE 1 on an interrupt is vectored
  assign vec     = VECTORED_EN != 0 && csr_mtvec[1:0] == 2'b01;
  assign tgt     = is_mret ? csr_mepc :
                   exc_op == 32'd3 ? (vec ? base + off : base) :
                   is_trap ? base : br_target;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE  ? (accept ? FLUSH : IDLE) :
               state == FLUSH ? (cnt == '0 ? REDIRECT : FLUSH) :
               (if_ready ? IDLE : REDIRECT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt    <= '0;
      tgt_q  <= '0;
      first  <= 1'b0;
      trap_k <= 1'b0;
      mret_k <= 1'b0;
    end else begin
      first <= accept;
      if (accept) begin
        tgt_q  <= tgt;
        trap_k <= is_trap;
        mret_k <= is_mret;
        cnt    <= is_exc ? 32'(TRAP_FLUSH-1) : 32'(BR_FLUSH-1);
      end else if (state == FLUSH && cnt != '0) begin
        cnt <= cnt - 32'd1;
      end
    end
  end
  // outputs decode only flops, so no input reaches an output combinationally
  always_comb begin
    flush        = state == FLUSH;
    new_pc_valid = state == REDIRECT;
    busy         = state != IDLE;
    new_pc       = tgt_q;
    trap_taken   = first && trap_k;
    mret_taken   = first && mret_k;
  end
endmodule

// File: tb/tb_ysyx_210247_redirect_ctrl.sv
// tb_ysyx_210247_redirect_ctrl: scoreboard bench for the redirect controller (vectored and direct-only instances)
module tb_ysyx_210247_redirect_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] exc_op = '0;
  logic [63:0] exc_cause = '0, csr_mepc = '0, csr_mtvec = '0, br_target = '0;
  logic br_valid = 1'b0, if_ready = 1'b0;
  logic flush0, nv0, tt0, mt0, busy0, flush1, nv1, tt1, mt1, busy1;
  logic [63:0] npc0, npc1;
  always #5 clk = ~clk;
  ysyx_210247_redirect_ctrl #(.VECTORED_EN(1)) dut0 (
    .clk(clk), .rst(rst), .exc_op(exc_op), .exc_cause(exc_cause), .csr_mepc(csr_mepc),
    .csr_mtvec(csr_mtvec), .br_valid(br_valid), .br_target(br_target), .if_ready(if_ready),
    .flush(flush0), .new_pc_valid(nv0), .new_pc(npc0), .trap_taken(tt0), .mret_taken(mt0), .busy(busy0));
  ysyx_210247_redirect_ctrl #(.VECTORED_EN(0)) dut1 (
    .clk(clk), .rst(rst), .exc_op(exc_op), .exc_cause(exc_cause), .csr_mepc(csr_mepc),
    .csr_mtvec(csr_mtvec), .br_valid(br_valid), .br_target(br_target), .if_ready(if_ready),
    .flush(flush1), .new_pc_valid(nv1), .new_pc(npc1), .trap_taken(tt1), .mret_taken(mt1), .busy(busy1));
  typedef struct {
    logic [63:0] pc0;
    logic [63:0] pc1;
    int nfl;
    int kind;
  } exp_t;
  exp_t q[$];
  exp_t e_m;
  int n_tests = 0;
  int n_fail = 0;
  int fl_cnt = 0;
  logic tt_seen = 1'b0, mt_seen = 1'b0, prev_v = 1'b0;
  logic [63:0] held = '0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst) begin
      fl_cnt = 0;
      prev_v = 1'b0;
      tt_seen = 1'b0;
      mt_seen = 1'b0;
    end else begin
      chk("busy", {63'b0, busy0}, {63'b0, flush0 | nv0});
      if (flush0 && fl_cnt == 0) begin
        tt_seen = tt0;
        mt_seen = mt0;
      end else begin
        chk("stray_pulse", {62'b0, tt0, mt0}, 64'd0);
      end
      if (flush0) fl_cnt++;
      if (nv0) begin
        if (prev_v) chk("new_pc_hold", npc0, held);
        held = npc0;
        if (if_ready) begin
          if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_redirect: got %h expected none", npc0);
          end else begin
            e_m = q.pop_front();
            chk("new_pc", npc0, e_m.pc0);
            chk("new_pc_direct_only", npc1, e_m.pc1);
            chk("direct_only_valid", {63'b0, nv1}, 64'd1);
            chk("flush_len", 64'(fl_cnt), 64'(e_m.nfl));
            chk("trap_taken", {63'b0, tt_seen}, {63'b0, e_m.kind == 1});
            chk("mret_taken", {63'b0, mt_seen}, {63'b0, e_m.kind == 2});
          end
          fl_cnt = 0;
        end
      end
      prev_v = nv0 && !if_ready;
    end
  end
  task automatic send(input logic [31:0] op, input logic [63:0] cause, mepc_i, mtvec_i,
                      input logic brv, input logic [63:0] brt, pc0, pc1,
                      input int nfl, kind, d, input bit noise);
    int k;
    exp_t e;
    exc_op = op;
    exc_cause = cause;
    csr_mepc = mepc_i;
    csr_mtvec = mtvec_i;
    br_valid = brv;
    br_target = brt;
    if (d == 0) if_ready = 1'b1;
    e.pc0 = pc0;
    e.pc1 = pc1;
    e.nfl = nfl;
    e.kind = kind;
    q.push_back(e);
    @(posedge clk); #1;
    exc_op = '0;
    exc_cause = '0;
    csr_mepc = '0;
    csr_mtvec = '0;
    br_valid = 1'b0;
    br_target = '0;
    if (noise) begin
      exc_op = 32'd1;
      br_valid = 1'b1;
      br_target = 64'hdead_beef;
    end
    k = 0;
    while (!nv0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!nv0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got no new_pc_valid expected %h", pc0);
    end
    exc_op = '0;
    br_valid = 1'b0;
    br_target = '0;
    if (d > 0) begin
      repeat (d) @(posedge clk);
      #1 if_ready = 1'b1;
    end
    @(posedge clk); #1;
    if_ready = 1'b0;
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_flush", {63'b0, flush0}, 64'd0);
    chk("rst_valid", {63'b0, nv0}, 64'd0);
    chk("rst_new_pc", npc0, 64'd0);
    chk("rst_pulses", {62'b0, tt0, mt0}, 64'd0);
    chk("rst_busy", {63'b0, busy0}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    send(32'd1, 64'd0, 64'd0, 64'h8000_0100, 1'b0, 64'd0, 64'h8000_0100, 64'h8000_0100, 4, 1, 2, 1'b0);
    send(32'd3, 64'h8000_0000_0000_0047, 64'd0, 64'h8000_0101, 1'b0, 64'd0, 64'h8000_011C, 64'h8000_0100, 4, 1, 0, 1'b0);
    send(32'd2, 64'd0, 64'h8000_1234, 64'h8000_0100, 1'b0, 64'd0, 64'h8000_1234, 64'h8000_1234, 4, 2, 0, 1'b0);
    send(32'd1, 64'd0, 64'd0, 64'h8000_0100, 1'b1, 64'h8000_2000, 64'h8000_0100, 64'h8000_0100, 4, 1, 1, 1'b0);
    send(32'd0, 64'd0, 64'd0, 64'd0, 1'b1, 64'h8000_2000, 64'h8000_2000, 64'h8000_2000, 1, 0, 0, 1'b1);
    send(32'd0, 64'd0, 64'd0, 64'd0, 1'b1, 64'h8000_2040, 64'h8000_2040, 64'h8000_2040, 1, 0, 0, 1'b0);
    send(32'd5, 64'd0, 64'd0, 64'h8000_0100, 1'b1, 64'h8000_3000, 64'h8000_3000, 64'h8000_3000, 1, 0, 1, 1'b0);
    send(32'd3, 64'h3F, 64'd0, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 64'd0, 64'hEC, 64'hFFFF_FFFF_FFFF_FFF0, 4, 1, 1, 1'b0);
    send(32'd3, 64'd5, 64'd0, 64'h8000_0103, 1'b0, 64'd0, 64'h8000_0100, 64'h8000_0100, 4, 1, 0, 1'b0);
    send(32'd1, 64'd9, 64'd0, 64'h8000_0101, 1'b0, 64'd0, 64'h8000_0100, 64'h8000_0100, 4, 1, 3, 1'b1);
    exc_op = 32'd1;
    csr_mtvec = 64'h8000_0100;
    @(posedge clk); #1;
    exc_op = '0;
    csr_mtvec = '0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst6_flush", {63'b0, flush0}, 64'd0);
    chk("rst6_valid", {63'b0, nv0}, 64'd0);
    chk("rst6_new_pc", npc0, 64'd0);
    chk("rst6_pulses", {62'b0, tt0, mt0}, 64'd0);
    chk("rst6_busy", {63'b0, busy0}, 64'd0);
    if_ready = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("no_valid_after_rst", {63'b0, nv0}, 64'd0);
    end
    if_ready = 1'b0;
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
